// File: rtl/md_unit_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: opcode encoding,
// FSM states and small opcode-classification helpers.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  // Ops that occupy the unit for WIDTH iterations.
  function automatic logic is_md_iter(input md_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_div_op(input md_op_t op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_signed_op(input md_op_t op);
    return op inside {MD_MULT, MD_DIV};
  endfunction

endpackage

// File: rtl/md_unit_iter_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_iter_if #(
  parameter int WIDTH = 32
);

  logic               start;
  md_pkg::md_op_t     op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               md_stall;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               div_zero;

  modport master (
    output start, op, a, b,
    input  busy, md_stall, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, md_stall, hi, lo, div_zero
  );

endinterface

// File: rtl/md_unit_iter_div_core.sv
// One restoring-division step on magnitudes, plus the sign fix-up applied
// to the stepped quotient/remainder so the final step can be written directly.
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             quo_neg_i,
  input  logic             rem_neg_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] quo_fix_o,
  output logic [WIDTH-1:0] rem_fix_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  // rem < divisor is invariant, so the shifted partial remainder fits WIDTH+1
  // bits and diff's top bit is a clean borrow flag.
  always_comb begin
    shifted   = {rem_i, quo_i[WIDTH-1]};
    diff      = shifted - {1'b0, divisor_i};
    ge        = ~diff[WIDTH];
    rem_o     = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_o     = {quo_i[WIDTH-2:0], ge};
    quo_fix_o = quo_neg_i ? -quo_o : quo_o;
    rem_fix_o = rem_neg_i ? -rem_o : rem_o;
  end

endmodule

// File: rtl/md_unit_iter.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiplier and
// restoring divider, one bit per cycle, busy for WIDTH cycles per operation.
module md_unit_iter
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  md_unit_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  md_op_t           op_q, op_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_flag_q, dz_flag_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             busy;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [2*WIDTH-1:0] mul_fix;
  logic [WIDTH-1:0] div_rem_nx, div_quo_nx, div_quo_fix, div_rem_fix;

  md_div_core #(.WIDTH(WIDTH)) u_div_core (
    .rem_i     (acc_hi_q),
    .quo_i     (acc_lo_q),
    .divisor_i (opnd_q),
    .quo_neg_i (res_neg_q),
    .rem_neg_i (rem_neg_q),
    .rem_o     (div_rem_nx),
    .quo_o     (div_quo_nx),
    .quo_fix_o (div_quo_fix),
    .rem_fix_o (div_rem_fix)
  );

  // Operand magnitudes at issue; the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    a_neg = is_signed_op(bus.op) & bus.a[WIDTH-1];
    b_neg = is_signed_op(bus.op) & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  // Multiplier step: acc_hi accumulates, acc_lo shifts the multiplier out LSB-first.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    mul_fix   = res_neg_q ? -{mul_hi_nx, mul_lo_nx} : {mul_hi_nx, mul_lo_nx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= MD_NOP;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_flag_q  <= 1'b0;
      div_zero_q <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      dz_flag_q  <= dz_flag_d;
      div_zero_q <= div_zero_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && is_md_iter(bus.op)) state_d = RUN;
      RUN:     if (cnt_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    op_d       = op_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    dz_flag_d  = dz_flag_q;
    div_zero_d = 1'b0;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (state_q == IDLE) begin
      if (bus.start && is_md_iter(bus.op)) begin
        op_d      = bus.op;
        cnt_d     = CW'(WIDTH);
        res_neg_d = a_neg ^ b_neg;
        rem_neg_d = a_neg;
        dz_flag_d = is_div_op(bus.op) && (bus.b == '0);
        // Divide keeps the dividend in acc_lo; multiply keeps the multiplier there.
        acc_hi_d  = '0;
        acc_lo_d  = is_div_op(bus.op) ? a_mag : b_mag;
        opnd_d    = is_div_op(bus.op) ? b_mag : a_mag;
      end else if (bus.start && bus.op == MD_MTHI) begin
        hi_d = bus.a;
      end else if (bus.start && bus.op == MD_MTLO) begin
        lo_d = bus.a;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (is_div_op(op_q)) begin
        acc_hi_d = div_rem_nx;
        acc_lo_d = div_quo_nx;
      end else begin
        acc_hi_d = mul_hi_nx;
        acc_lo_d = mul_lo_nx;
      end
      if (cnt_q == CW'(1)) begin
        if (!is_div_op(op_q)) begin
          {hi_d, lo_d} = mul_fix;
        end else if (dz_flag_q) begin
          div_zero_d = 1'b1;
        end else begin
          hi_d = div_rem_fix;
          lo_d = div_quo_fix;
        end
      end
    end
  end

  assign busy         = (state_q == RUN);
  assign bus.busy     = busy;
  assign bus.md_stall = busy | (bus.start & is_md_iter(bus.op));
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;

endmodule
